// File: rtl/keypad_timer_loader.sv
// Keypad digit loader: debounces encoder presses and shifts accepted decimal
// digits right-to-left into a four-digit BCD MM:SS register.
module keypad_timer_loader #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] D,
   input  logic       valid,
   input  logic       entry_en,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       digit_loaded,
   output logic       is_zero
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1) + 1;
   localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic [3:0]    code, code_nx;
   logic          accept;
   logic          store;

   assign cnt_inc = cnt + CW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         code  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         code  <= code_nx;
      end
   end

   // The counter "reaching" LAST is judged on its incremented value, so a key
   // stable from cycle 0 pulses digit_loaded in cycle DEBOUNCE_CYCLES.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      code_nx  = code;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               code_nx  = D;
               cnt_nx   = '0;
               state_nx = PRESS_DB;
            end
         end
         PRESS_DB: begin
            if (!valid) begin
               state_nx = IDLE;
            end else if (D != code) begin
               code_nx = D;
               cnt_nx  = '0;
            end else if (cnt_inc >= LAST) begin
               accept   = 1'b1;
               cnt_nx   = '0;
               state_nx = HELD;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         HELD: begin
            if (!valid) begin
               cnt_nx   = '0;
               state_nx = RELEASE_DB;
            end
         end
         RELEASE_DB: begin
            if (valid) begin
               state_nx = HELD;
            end else if (cnt_inc >= LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign store = accept && entry_en && (code <= 4'd9);

   // clear has priority over a simultaneous accepted digit
   always_ff @(posedge clock) begin
      if (reset) begin
         min_tens     <= '0;
         min_ones     <= '0;
         sec_tens     <= '0;
         sec_ones     <= '0;
         digit_loaded <= 1'b0;
      end else begin
         digit_loaded <= 1'b0;
         if (clear) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
         end else if (store) begin
            min_tens     <= min_ones;
            min_ones     <= sec_tens;
            sec_tens     <= sec_ones;
            sec_ones     <= code;
            digit_loaded <= 1'b1;
         end
      end
   end

   assign is_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);

endmodule

// File: tb/tb_keypad_timer_loader.sv
// Directed bench for keypad_timer_loader with hand-computed expected digits.
module tb_keypad_timer_loader;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] D;
   logic       valid;
   logic       entry_en;
   logic       clear;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       digit_loaded;
   logic       is_zero;

   int errors = 0;
   int checks = 0;
   int pulses;
   int first;

   keypad_timer_loader #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .D(D), .valid(valid),
      .entry_en(entry_en), .clear(clear),
      .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones),
      .digit_loaded(digit_loaded), .is_zero(is_zero)
   );

   always #5 clock = ~clock;

   function automatic int digits();
      return int'({min_tens, min_ones, sec_tens, sec_ones});
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Press d for 'hold' cycles (optionally switching to d2 at cycle chg_at and
   // pulsing clear at cycle clr_at), then release for 6 cycles. Reports the
   // number of digit_loaded pulses and the cycle of the first one.
   task automatic press(input logic [3:0] d, input int hold, input int chg_at,
                        input logic [3:0] d2, input int clr_at,
                        output int np, output int fc);
      np = 0;
      fc = -1;
      D = d;
      valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (i == chg_at) D = d2;
         clear = (i == clr_at);
         tick();
         if (digit_loaded) begin
            if (fc < 0) fc = i + 1;
            np++;
         end
      end
      clear = 1'b0;
      valid = 1'b0;
      D = 4'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (digit_loaded) np++;
      end
   endtask

   initial begin
      reset = 1'b1; D = 4'd0; valid = 1'b0; entry_en = 1'b1; clear = 1'b0;
      #1;
      tick();
      tick();
      chk("reset_digits", digits(), 0);
      chk("reset_is_zero", int'(is_zero), 1);
      chk("reset_loaded", int'(digit_loaded), 0);
      reset = 1'b0;

      press(4'd5, 6, -1, 4'd0, -1, pulses, first);
      chk("key5_pulses", pulses, 1);
      chk("key5_latency", first, 4);
      chk("key5_digits", digits(), 'h0005);
      chk("key5_is_zero", int'(is_zero), 0);

      press(4'd1, 6, -1, 4'd0, -1, pulses, first);
      press(4'd2, 6, -1, 4'd0, -1, pulses, first);
      press(4'd3, 6, -1, 4'd0, -1, pulses, first);
      press(4'd4, 6, -1, 4'd0, -1, pulses, first);
      chk("seq_1234", digits(), 'h1234);
      press(4'd5, 6, -1, 4'd0, -1, pulses, first);
      chk("seq_drop_msd", digits(), 'h2345);

      // bounce: valid 1,0,1,0 then stable with D=7
      pulses = 0;
      D = 4'd7;
      for (int i = 0; i < 4; i++) begin
         valid = (i % 2 == 0);
         tick();
         if (digit_loaded) pulses++;
      end
      chk("bounce_no_early_load", pulses, 0);
      press(4'd7, 8, -1, 4'd0, -1, pulses, first);
      chk("bounce_pulses", pulses, 1);
      chk("bounce_latency", first, 4);
      chk("bounce_digits", digits(), 'h3457);

      // long hold, code changes to 8 while HELD
      press(4'd3, 20, 10, 4'd8, -1, pulses, first);
      chk("hold_pulses", pulses, 1);
      chk("hold_digits", digits(), 'h4573);
      press(4'd8, 6, -1, 4'd0, -1, pulses, first);
      chk("repress8_pulses", pulses, 1);
      chk("repress8_digits", digits(), 'h5738);

      entry_en = 1'b0;
      press(4'd9, 6, -1, 4'd0, -1, pulses, first);
      chk("entry_off_pulses", pulses, 0);
      chk("entry_off_digits", digits(), 'h5738);
      entry_en = 1'b1;
      press(4'd12, 6, -1, 4'd0, -1, pulses, first);
      chk("code12_pulses", pulses, 0);
      chk("code12_digits", digits(), 'h5738);

      // clear during the acceptance cycle of key 6
      press(4'd6, 6, -1, 4'd0, 3, pulses, first);
      chk("clear_pulses", pulses, 0);
      chk("clear_digits", digits(), 0);
      chk("clear_is_zero", int'(is_zero), 1);

      // reset in PRESS_DB with counter at 2 and digits 0042
      press(4'd4, 6, -1, 4'd0, -1, pulses, first);
      press(4'd2, 6, -1, 4'd0, -1, pulses, first);
      chk("pre_reset_digits", digits(), 'h0042);
      D = 4'd1;
      valid = 1'b1;
      tick();
      tick();
      tick();
      chk("pre_reset_no_load", int'(digit_loaded), 0);
      reset = 1'b1;
      tick();
      chk("midreset_digits", digits(), 0);
      chk("midreset_is_zero", int'(is_zero), 1);
      chk("midreset_loaded", int'(digit_loaded), 0);
      reset = 1'b0;
      press(4'd1, 8, -1, 4'd0, -1, pulses, first);
      chk("post_reset_pulses", pulses, 1);
      chk("post_reset_latency", first, 4);
      chk("post_reset_digits", digits(), 'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_timer_loader.md
Name: keypad_timer_loader

Overview:
- Consumes the 4-bit digit code (D) and valid flag produced by the keypad priority encoder.
- Debounces each key press and accepts it once per press-release cycle.
- Shifts each accepted decimal digit into a 4-digit BCD timer register (MM:SS, right-entry like a microwave keypad).
- The stored value feeds the downstream countdown timer, which loads it when told to start.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a press, or a release, is accepted (minimum 1).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- D  input  4  digit code from the encoder, meaningful only while valid=1
- valid  input  1  encoder reports at least one key pressed
- entry_en  input  1  digit entry allowed; when 0, presses are tracked but not stored
- clear  input  1  synchronous clear of the stored digits
- min_tens  output  4  BCD digit 3 (most significant)
- min_ones  output  4  BCD digit 2
- sec_tens  output  4  BCD digit 1
- sec_ones  output  4  BCD digit 0 (least significant)
- digit_loaded  output  1  one-cycle pulse in the cycle the digit register is updated by a press
- is_zero  output  1  1 when all four digits are 0

Behaviour:
- Reset:
  - All digits 0, digit_loaded=0, is_zero=1.
  - FSM goes to IDLE, debounce counter 0, captured code 0.
  - Reset overrides every other input.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - If valid=1, capture D, clear the counter and go to PRESS_DB.
- PRESS_DB: each cycle, in priority order:
  - valid=0: back to IDLE.
  - D differs from the captured code: recapture D and restart the counter; stay in PRESS_DB.
  - Otherwise increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with valid=1 and D equal to the capture, accept the press and go to HELD.
- Accepting a press:
  - If entry_en=1 and the captured code is 0..9, shift on that same clock edge: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=code. The old min_tens is discarded.
  - digit_loaded is 1 for exactly the cycle after that edge.
  - Codes 10..15, or entry_en=0: no shift and no pulse, but still go to HELD.
- Latency: with D and valid held stable from cycle 0, digit_loaded is asserted in cycle DEBOUNCE_CYCLES (4 with the default).
- HELD:
  - No further loads, whatever D does (no auto-repeat).
  - On valid=0, clear the counter and go to RELEASE_DB.
- RELEASE_DB:
  - valid=1: back to HELD.
  - Otherwise increment the counter; at DEBOUNCE_CYCLES-1 go to IDLE.
  - A new press is recognised only after passing through IDLE.
- clear:
  - Zeroes all four digits on the next edge and does not change the FSM state.
  - If clear and a press acceptance happen in the same cycle, clear wins: digits become 0 and digit_loaded stays 0.
- is_zero is combinational from the registered digits.
- Digits are never checked for time validity (e.g. sec_tens>5); normalisation belongs to the countdown block.
- Reset mid-operation (any state, counter mid-count): next cycle is the full reset state; a key still held after reset is debounced again from IDLE and loads once.

Test Plan:
- Reset, then press key 5 (D=5, valid=1) for 6 cycles, then release -> digit_loaded pulses once in cycle 4; sec_ones=5, other digits 0; is_zero=0.
- Enter 1,2,3,4,5 with a full press/release each -> shift order 1,2,3,4 gives 12:34; the fifth digit drops 1 and the final register is min_tens=2, min_ones=3, sec_tens=4, sec_ones=5.
- Bounce: valid toggles 1,0,1,0 for 1 cycle each, then holds 1 with D=7 -> exactly one load of 7, occurring DEBOUNCE_CYCLES cycles after the stable hold starts.
- Hold D=3 for 20 cycles, and change D to 8 while in HELD -> a single load of 3 and no load of 8; release, then press 8 again -> 8 loads.
- entry_en=0 during a press of 9 -> no shift and no pulse; press D=12 with entry_en=1 -> no shift; clear asserted in the acceptance cycle of a press of 6 -> all digits 0 and digit_loaded=0.
- Assert reset while in PRESS_DB with the counter at 2 and digits at 0,0,4,2 -> all digits 0 and is_zero=1 next cycle; a key still held afterwards loads once after DEBOUNCE_CYCLES.
